mul_wallace_pipe: RTL
=====================

Name: mul_wallace_pipe

Overview:
- Pipelined RV32M multiplier front end for the execute-stage mul_div unit. Covers MUL, MULH, MULHSU and MULHU.
- Registers the operands and generates partial products.
- Reduces the partial products with a Wallace tree to a sum/carry pair and registers that pair.
- Feeds the pair to the existing carry-lookahead adder wrapper (op=0, XLEN=64) for the final carry-propagate add.
- Selects the upper or lower half of the product for writeback.

Parameters:
- XLEN, 32, operand and result width.
- PW, 2*XLEN, full product width presented to the final adder.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill all in-flight operations (branch mispredict or trap)
- in_valid_i  in  1  request valid
- in_ready_o  out  1  block can accept a request this cycle
- op_i  in  2  mul_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3
- rs1_i  in  XLEN  multiplicand
- rs2_i  in  XLEN  multiplier
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  XLEN  selected product half

Behaviour:
- Pipeline S1 (operand regs) -> S2 (sum/carry regs) -> S3 (result reg). Each stage has a valid bit.
- Latency: request accepted at edge N -> out_valid_o high after edge N+3. Throughput is 1 per cycle when there is no backpressure.
- Sign extension to XLEN+1 bits:
  - rs1 signed for MULH and MULHSU.
  - rs2 signed for MULH only.
  - MUL treated as unsigned; the low half is identical either way.
- Product formed mod 2^PW. S2 holds the PW-bit sum and carry vectors, sign-correction constants already folded in.
- S3 computes sum + carry through the add wrapper; carry-out is discarded.
- Result: MUL -> product[XLEN-1:0]; all other ops -> product[PW-1:XLEN].
- Handshake:
  - in_ready_o = !s3_valid | out_ready_i. The pipeline advances as a whole.
  - Stall when s3_valid && !out_ready_i: all stage registers and valids hold.
  - A request is accepted only when in_valid_i && in_ready_o.
- Flush: at the next edge all valid bits clear, so in-flight ops are lost and out_valid_o goes low. A request presented the same cycle as flush_i is dropped. Data registers need not clear.
- Simultaneous accept and output handshake in one cycle: both happen and the pipeline shifts.
- Reset (asynchronous, any time, including mid-operation):
  - all valid bits 0, out_valid_o = 0, result_o = 0, in_ready_o = 1 after reset.
  - Operand, sum/carry and op registers reset to 0.
- result_o holds its last value while out_valid_o = 0. It changes only on an S3 load.

Optional Feature:
- Macro: MUL_RESULT_REUSE_EN.
- With it defined:
  - Retain the last completed PW-bit product, its rs1, rs2 and sign mode (rs1 signed, rs2 signed), plus a tag-valid bit. The tag-valid bit is cleared by reset, not by flush.
  - A new request hits when the operands match and either the sign mode matches or op==MUL.
  - A hit is taken only when S1 and S2 are empty.
  - On a hit, the result is written directly into S3 one edge after acceptance, so latency is 1.
  - On a miss, the normal 3-cycle path is used.
- Without it: no tag storage; every request takes 3 cycles.

Decomposition:
- Shared package configure:
  - mul_op_e enum.
  - constant MUL_LAT = 3.
  - typedef for the S1 payload struct {op, a_ext, b_ext}.
- One sub-module, wallace_reduce:
  - Combinational partial-product generation and 3:2 compressor tree.
  - Inputs: two XLEN+1-bit operands. Outputs: PW-bit sum and carry vectors.
  - Instantiated between S1 and S2.
- The final add reuses the existing add wrapper (XLEN=PW, op=0).

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid 3 cycles after accept.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF -> 0xFFFFFFFF. Same operands with MULHU -> 0xFFFFFFFE.
- Back-to-back 4 requests with out_ready_i low for 2 cycles after the first result:
  - in_ready_o drops.
  - All 4 results emerge in order, none lost or duplicated.
- flush_i while 2 ops are in flight, then one new MUL 3x5 -> only 15 delivered.
- rst_ni pulsed low mid-pipeline -> out_valid_o = 0 and result_o = 0 immediately, in_ready_o = 1 after release.
- With MUL_RESULT_REUSE_EN: MULH a,b then MUL a,b on an empty pipeline -> second result after 1 cycle and equals the independent MUL.

Source files
------------

// File: rtl/mul_wallace_pipe_pkg.sv
// Shared types and constants for the pipelined RV32M multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mul_wallace_pipe_pkg;

    localparam int MUL_XLEN = 32;
    // Edges from request handshake to out_valid_o on the full (non-reuse) path.
    localparam int MUL_LAT  = 3;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    // Operands are carried one bit wider so signed and unsigned forms
    // share a single signed (XLEN+1)x(XLEN+1) multiply.
    typedef struct packed {
        mul_op_e             op;
        logic [MUL_XLEN:0]   a_ext;
        logic [MUL_XLEN:0]   b_ext;
    } s1_pay_t;

    function automatic logic rs1_is_signed(input mul_op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input mul_op_e op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/add_wrap.sv
// Generic add/subtract wrapper used for final carry-propagate adds.
// Latency: combinational.
// Backpressure: none (pure datapath).
// Ports: op_i (0 = add, 1 = subtract), a_i, b_i operands, sum_o result.
// The carry-out is not exported; callers that need modular sums only.
module add_wrap #(
    parameter int XLEN = 32
) (
    input  logic            op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] sum_o
);

    logic [XLEN-1:0] b_eff;
    logic [XLEN-1:0] cin;

    assign b_eff = op_i ? ~b_i : b_i;
    assign cin   = {{(XLEN-1){1'b0}}, op_i};
    assign sum_o = a_i + b_eff + cin;

endmodule

// File: rtl/wallace_reduce.sv
// Partial-product generation and 3:2 compressor (Wallace) tree.
// Latency: combinational.
// Backpressure: none (pure datapath).
// Ports: a_i, b_i are (XLEN+1)-bit two's-complement operands; sum_o and
// carry_o are PW-bit vectors whose modular sum is a_i * b_i mod 2^PW.
module wallace_reduce
    import mul_wallace_pipe_pkg::*;
#(
    parameter int XLEN = MUL_XLEN,
    parameter int PW   = 2 * XLEN
) (
    input  logic [XLEN:0]   a_i,
    input  logic [XLEN:0]   b_i,
    output logic [PW-1:0]   sum_o,
    output logic [PW-1:0]   carry_o
);

    // XLEN positive rows, one negated row for the multiplier sign bit,
    // and one row carrying the +1 that completes that negation.
    localparam int NROWS = XLEN + 2;

    function automatic int next_rows(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int num_levels(input int n);
        int cnt;
        int rows;
        cnt  = 0;
        rows = n;
        while (rows > 2) begin
            rows = next_rows(rows);
            cnt++;
        end
        return cnt;
    endfunction

    localparam int NLVL = num_levels(NROWS);

    logic [PW-1:0] a_sx;
    logic [PW-1:0] cur [NROWS];
    logic [PW-1:0] nxt [NROWS];
    int            n;
    int            grp;
    int            idx;

    always_comb begin
        a_sx = {{(PW-XLEN-1){a_i[XLEN]}}, a_i};
        for (int r = 0; r < NROWS; r++) begin
            cur[r] = '0;
            nxt[r] = '0;
        end
        for (int i = 0; i < XLEN; i++) begin
            cur[i] = b_i[i] ? (a_sx << i) : '0;
        end
        // Sign bit of b has weight -2^XLEN: -(A<<XLEN) = (~A<<XLEN) + 2^XLEN.
        cur[XLEN]   = b_i[XLEN] ? ((~a_sx) << XLEN) : '0;
        cur[XLEN+1] = b_i[XLEN] ? (PW'(1) << XLEN) : '0;

        n   = NROWS;
        grp = 0;
        idx = 0;
        for (int l = 0; l < NLVL; l++) begin
            for (int r = 0; r < NROWS; r++) begin
                nxt[r] = '0;
            end
            grp = n / 3;
            for (int g = 0; g < NROWS / 3; g++) begin
                if (g < grp) begin
                    nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                    nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) |
                                  (cur[3*g] & cur[3*g+2]) |
                                  (cur[3*g+1] & cur[3*g+2])) << 1;
                end
            end
            // Rows left over after grouping pass straight to the next level.
            for (int r = 0; r < NROWS; r++) begin
                if ((r >= 3 * grp) && (r < n)) begin
                    idx      = r - grp;
                    nxt[idx] = cur[r];
                end
            end
            n = next_rows(n);
            for (int r = 0; r < NROWS; r++) begin
                cur[r] = nxt[r];
            end
        end
        sum_o   = cur[0];
        carry_o = cur[1];
    end

endmodule

// File: rtl/mul_wallace_pipe.sv
// Pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU): operand regs, Wallace sum/carry regs, result reg.
// Latency: 3 edges from request handshake to out_valid_o (1 on a reuse hit when MUL_RESULT_REUSE_EN is defined).
// Backpressure: whole pipeline stalls while a result is held and out_ready_i is low; in_ready_o = !s3_valid | out_ready_i.
// Ports: clk_i, rst_ni (async active-low), flush_i kills in-flight ops,
// in_valid_i/in_ready_o + op_i/rs1_i/rs2_i request, out_valid_o/out_ready_i + result_o response.
// Optional macro MUL_RESULT_REUSE_EN: retain last product and bypass to S3 on an operand/sign-mode match.
module mul_wallace_pipe
    import mul_wallace_pipe_pkg::*;
#(
    parameter int XLEN = MUL_XLEN,
    parameter int PW   = 2 * XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    function automatic logic [XLEN-1:0] pick_half(input mul_op_e op, input logic [PW-1:0] p);
        return (op == MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
    endfunction

    mul_op_e         op_in;
    s1_pay_t         in_pay;
    s1_pay_t         s1_q;
    logic            s1_valid;
    logic            s2_valid;
    logic            s3_valid;
    mul_op_e         s2_op;
    logic [PW-1:0]   s2_sum;
    logic [PW-1:0]   s2_carry;
    logic [PW-1:0]   red_sum;
    logic [PW-1:0]   red_carry;
    logic [PW-1:0]   prod;
    logic            adv;
    logic            take;
    logic            hit;
    logic [XLEN-1:0] hit_result;

    assign op_in = mul_op_e'(op_i);

    always_comb begin
        in_pay.op    = op_in;
        in_pay.a_ext = {rs1_is_signed(op_in) & rs1_i[XLEN-1], rs1_i};
        in_pay.b_ext = {rs2_is_signed(op_in) & rs2_i[XLEN-1], rs2_i};
    end

    assign in_ready_o  = !s3_valid | out_ready_i;
    assign adv         = in_ready_o;
    // A request alongside flush is dropped rather than accepted.
    assign take        = in_valid_i & in_ready_o & ~flush_i;
    assign out_valid_o = s3_valid;

    wallace_reduce #(.XLEN(XLEN), .PW(PW)) u_reduce (
        .a_i     (s1_q.a_ext),
        .b_i     (s1_q.b_ext),
        .sum_o   (red_sum),
        .carry_o (red_carry)
    );

    add_wrap #(.XLEN(PW)) u_final_add (
        .op_i  (1'b0),
        .a_i   (s2_sum),
        .b_i   (s2_carry),
        .sum_o (prod)
    );

`ifdef MUL_RESULT_REUSE_EN
    logic [XLEN-1:0] s2_rs1;
    logic [XLEN-1:0] s2_rs2;
    logic            tag_vld;
    logic [PW-1:0]   tag_prod;
    logic [XLEN-1:0] tag_rs1;
    logic [XLEN-1:0] tag_rs2;
    logic            tag_s1;
    logic            tag_s2;
    logic            tag_match;

    // MUL only needs the low half, which is identical for every sign mode.
    assign tag_match = tag_vld && (rs1_i == tag_rs1) && (rs2_i == tag_rs2) &&
                       ((op_in == MUL) ||
                        ((rs1_is_signed(op_in) == tag_s1) && (rs2_is_signed(op_in) == tag_s2)));
    // Bypass only into an empty pipe so S3 never sees two loads at once.
    assign hit        = take & tag_match & ~s1_valid & ~s2_valid;
    assign hit_result = pick_half(op_in, tag_prod);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_rs1 <= '0;
            s2_rs2 <= '0;
        end else if (adv && s1_valid) begin
            s2_rs1 <= s1_q.a_ext[XLEN-1:0];
            s2_rs2 <= s1_q.b_ext[XLEN-1:0];
        end
    end

    // Tag survives flush: it describes a completed product, not an in-flight op.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_vld  <= 1'b0;
            tag_prod <= '0;
            tag_rs1  <= '0;
            tag_rs2  <= '0;
            tag_s1   <= 1'b0;
            tag_s2   <= 1'b0;
        end else if (!flush_i && adv && s2_valid) begin
            tag_vld  <= 1'b1;
            tag_prod <= prod;
            tag_rs1  <= s2_rs1;
            tag_rs2  <= s2_rs2;
            tag_s1   <= rs1_is_signed(s2_op);
            tag_s2   <= rs2_is_signed(s2_op);
        end
    end
`else
    assign hit        = 1'b0;
    assign hit_result = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= take & ~hit;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid | hit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
        end else if (adv && take && !hit) begin
            s1_q <= in_pay;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_op    <= MUL;
            s2_sum   <= '0;
            s2_carry <= '0;
        end else if (adv && s1_valid) begin
            s2_op    <= s1_q.op;
            s2_sum   <= red_sum;
            s2_carry <= red_carry;
        end
    end

    // result_o only moves on a real S3 load, so it holds while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_o <= '0;
        end else if (!flush_i && adv) begin
            if (hit) begin
                result_o <= hit_result;
            end else if (s2_valid) begin
                result_o <= pick_half(s2_op, prod);
            end
        end
    end

endmodule
